dmem_responder: RTL and testbench

- Memory-side responder for the datapath's data-memory port (mem_addr / mem_wr_data / mem_rd / mem_wr / mem_rd_data).
- Adds a stall/done handshake and byte enables, so the datapath can target memory with multi-cycle latency instead of a single-cycle dcache.
- Backed by an internal word array with a programmable number of wait cycles.
- Sits between datapath and the data store, alongside icache at the CPU top level.

---
 rtl/dmem_pkg.sv | 32 +++
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_array.sv | 41 ++++
 rtl/dmem_responder.sv | 142 ++++++++++++++
 tb/tb_dmem_responder.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned BE_W        = 4;
    localparam int unsigned MAX_LATENCY = 15;
    localparam int unsigned CNT_W       = $clog2(MAX_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } op_t;

    // A request is bad if misaligned, beyond the array, or both read and write.
    function automatic logic req_error(
        input logic [WORD_W-1:0] addr,
        input logic              rd,
        input logic              wr,
        input int unsigned       depth
    );
        return (addr[1:0] != 2'b00)
            || ({2'b00, addr[WORD_W-1:2]} >= depth)
            || (rd && wr);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Datapath <-> data-memory port with stall/done handshake and byte enables.
interface dmem_responder_if;
    import dmem_pkg::*;

    logic [WORD_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wr_data;
    logic [BE_W-1:0]   mem_be;
    logic              mem_rd;
    logic              mem_wr;
    logic [WORD_W-1:0] mem_rd_data;
    logic              mem_stall;
    logic              mem_done;
    logic              mem_err;

    modport master (
        output mem_addr, mem_wr_data, mem_be, mem_rd, mem_wr,
        input  mem_rd_data, mem_stall, mem_done, mem_err
    );

    modport slave (
        input  mem_addr, mem_wr_data, mem_be, mem_rd, mem_wr,
        output mem_rd_data, mem_stall, mem_done, mem_err
    );

endinterface

// File: rtl/dmem_array.sv
// DEPTH x 32 word store: synchronous byte-lane write, registered read port.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH  = 128,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [BE_W-1:0]   be,
    input  logic              rd_en,
    input  logic              rd_clr,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Commit only the enabled byte lanes; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Read register: loads a word (or zero for an errored access) and holds it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_clr ? '0 : mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts a request, waits LATENCY cycles,
// then pulses mem_done (with mem_err on bad requests).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 128,
    parameter int unsigned LATENCY = 2
) (
    input logic             clk,
    input logic             rst,
    dmem_responder_if.slave bus
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [ADDR_W-1:0] idx_q;
    logic [WORD_W-1:0] wr_data_q;
    logic [BE_W-1:0]   be_q;
    op_t               op_q;
    logic              err_q;

    logic              req;
    logic              live_err;
    op_t               live_op;
    logic              capture;
    logic              enter_resp;

    logic [ADDR_W-1:0] c_idx;
    logic [WORD_W-1:0] c_data;
    logic [BE_W-1:0]   c_be;
    op_t               c_op;
    logic              c_err;
    logic              arr_wr;
    logic              arr_rd;

    assign req      = bus.mem_rd || bus.mem_wr;
    assign live_err = req_error(bus.mem_addr, bus.mem_rd, bus.mem_wr, DEPTH);
    assign live_op  = (bus.mem_wr && !bus.mem_rd) ? OP_WR : OP_RD;

    // State and wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, counter load/decrement, capture and commit strobes.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        capture    = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    capture = 1'b1;
                    if (LATENCY > 1) begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LATENCY - 2);
                    end else begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Hold the accepted request so WAIT ignores whatever the bus shows.
    always_ff @(posedge clk) begin
        if (capture) begin
            idx_q     <= bus.mem_addr[ADDR_W+1:2];
            wr_data_q <= bus.mem_wr_data;
            be_q      <= bus.mem_be;
            op_q      <= live_op;
            err_q     <= live_err;
        end
    end

    // With LATENCY=1 the commit edge is also the capture edge, so the live
    // bus feeds the array from IDLE and the captured copy from WAIT.
    always_comb begin
        if (state_q == IDLE) begin
            c_idx  = bus.mem_addr[ADDR_W+1:2];
            c_data = bus.mem_wr_data;
            c_be   = bus.mem_be;
            c_op   = live_op;
            c_err  = live_err;
        end else begin
            c_idx  = idx_q;
            c_data = wr_data_q;
            c_be   = be_q;
            c_op   = op_q;
            c_err  = err_q;
        end
    end

    // Reset on the commit edge discards the pending access.
    assign arr_wr = enter_resp && !rst && !c_err && (c_op == OP_WR);
    assign arr_rd = enter_resp && !rst && (c_err || (c_op == OP_RD));

    dmem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (arr_wr),
        .addr    (c_idx),
        .wr_data (c_data),
        .be      (c_be),
        .rd_en   (arr_rd),
        .rd_clr  (c_err),
        .rd_data (bus.mem_rd_data)
    );

    assign bus.mem_stall = !rst && (((state_q == IDLE) && req) || (state_q == WAIT));
    assign bus.mem_done  = (state_q == RESP);
    assign bus.mem_err   = (state_q == RESP) && err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=2 and LATENCY=1 instances side by side.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int unsigned LAT2 = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dmem_responder_if if2 ();
    dmem_responder_if if1 ();

    dmem_responder #(.DEPTH(128), .LATENCY(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2)
    );

    dmem_responder #(.DEPTH(128), .LATENCY(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        exp_err;
        logic [31:0] exp_data;
        logic        chk_data;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] data;
        logic        chk;
        int          id;
    } exp_t;

    exp_t sb2[$];
    exp_t sb1[$];
    int   checks   = 0;
    int   failures = 0;
    int   txn_id   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] data, input logic [3:0] be,
                                input logic exp_err, input logic [31:0] exp_data,
                                input logic chk_data);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.data = data; v.be = be;
        v.exp_err = exp_err; v.exp_data = exp_data; v.chk_data = chk_data;
        return v;
    endfunction

    // Scoreboard for the LATENCY=2 instance: pop on every done pulse.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (if2.mem_done === 1'b1) begin
                chk("l2_done_expected", 32'(sb2.size() != 0), 32'd1);
                if (sb2.size() != 0) begin
                    exp_t e;
                    e = sb2.pop_front();
                    chk($sformatf("l2_err[%0d]", e.id), 32'(if2.mem_err), 32'(e.err));
                    if (e.chk) chk($sformatf("l2_rd_data[%0d]", e.id), if2.mem_rd_data, e.data);
                end
            end else begin
                chk("l2_err_without_done", 32'(if2.mem_err), 32'd0);
            end
        end
    end

    // Scoreboard for the LATENCY=1 instance.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (if1.mem_done === 1'b1) begin
                chk("l1_done_expected", 32'(sb1.size() != 0), 32'd1);
                if (sb1.size() != 0) begin
                    exp_t e;
                    e = sb1.pop_front();
                    chk($sformatf("l1_err[%0d]", e.id), 32'(if1.mem_err), 32'(e.err));
                    if (e.chk) chk($sformatf("l1_rd_data[%0d]", e.id), if1.mem_rd_data, e.data);
                end
            end else begin
                chk("l1_err_without_done", 32'(if1.mem_err), 32'd0);
            end
        end
    end

    // Present one request to the LATENCY=2 instance and hold it until done.
    // start_cyc=1 means the acceptance cycle has already been sampled.
    task automatic run_txn(input vec_t v, input int unsigned start_cyc);
        exp_t e;
        bit   seen;
        seen = 1'b0;
        if2.mem_rd      = v.rd;
        if2.mem_wr      = v.wr;
        if2.mem_addr    = v.addr;
        if2.mem_wr_data = v.data;
        if2.mem_be      = v.be;
        e.err = v.exp_err; e.data = v.exp_data; e.chk = v.chk_data; e.id = txn_id;
        txn_id++;
        sb2.push_back(e);
        for (int unsigned cyc = start_cyc; cyc <= 20 && !seen; cyc++) begin
            @(negedge clk);
            chk($sformatf("l2_stall[%0d]c%0d", e.id, cyc), 32'(if2.mem_stall), 32'(cyc < LAT2));
            if (if2.mem_done === 1'b1) begin
                seen = 1'b1;
                chk($sformatf("l2_latency[%0d]", e.id), cyc, LAT2);
            end
            @(posedge clk); #1;
        end
        if (!seen) chk($sformatf("l2_timeout[%0d]", e.id), 32'(seen), 32'd1);
        if2.mem_rd = 1'b0;
        if2.mem_wr = 1'b0;
    endtask

    initial begin
        vec_t        vecs[$];
        vec_t        l1v[$];
        int unsigned k;
        int unsigned cyc;
        int unsigned dones;
        bit          got;

        // ---------------- reset with a pending read ----------------
        rst = 1'b1;
        if2.mem_rd = 1'b1; if2.mem_wr = 1'b0; if2.mem_addr = 32'h10;
        if2.mem_wr_data = '0; if2.mem_be = 4'hF;
        if1.mem_rd = 1'b0; if1.mem_wr = 1'b0; if1.mem_addr = '0;
        if1.mem_wr_data = '0; if1.mem_be = 4'h0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_stall_l2", 32'(if2.mem_stall), 32'd0);
            chk("rst_stall_l1", 32'(if1.mem_stall), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rd_data_l2", if2.mem_rd_data, 32'h0);
        chk("rst_done_l2", 32'(if2.mem_done), 32'd0);
        chk("rst_err_l2", 32'(if2.mem_err), 32'd0);
        chk("rst_rd_data_l1", if1.mem_rd_data, 32'h0);
        chk("post_rst_accept_stall", 32'(if2.mem_stall), 32'd1);
        @(posedge clk); #1;
        run_txn(mk(1, 0, 32'h10, 32'h0, 4'hF, 0, 32'h0, 0), 1);

        // ---------------- table of LATENCY=2 transactions ----------------
        vecs.push_back(mk(0, 1, 32'h10,  32'hDEADBEEF, 4'hF, 0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 32'h10,  32'h0,        4'hF, 0, 32'hDEADBEEF, 1));
        vecs.push_back(mk(0, 1, 32'h10,  32'h0000CAFE, 4'h3, 0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 32'h10,  32'h0,        4'hF, 0, 32'hDEADCAFE, 1));
        vecs.push_back(mk(1, 0, 32'h13,  32'h0,        4'hF, 1, 32'h0,        1));
        vecs.push_back(mk(1, 0, 32'h200, 32'h0,        4'hF, 1, 32'h0,        1));
        vecs.push_back(mk(1, 1, 32'h10,  32'hFFFFFFFF, 4'hF, 1, 32'h0,        1));
        vecs.push_back(mk(1, 0, 32'h10,  32'h0,        4'hF, 0, 32'hDEADCAFE, 1));
        vecs.push_back(mk(0, 1, 32'h14,  32'hA5A5A5A5, 4'hF, 0, 32'h0,        0));
        vecs.push_back(mk(0, 1, 32'h14,  32'h12345678, 4'h0, 0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 32'h14,  32'h0,        4'hF, 0, 32'hA5A5A5A5, 1));
        vecs.push_back(mk(0, 1, 32'h44,  32'h00000000, 4'hF, 0, 32'h0,        0));
        vecs.push_back(mk(0, 1, 32'h44,  32'hAABBCCDD, 4'h4, 0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 32'h44,  32'h0,        4'hF, 0, 32'h00BB0000, 1));
        vecs.push_back(mk(0, 1, 32'h1FC, 32'h01020304, 4'hF, 0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 32'h1FC, 32'h0,        4'hF, 0, 32'h01020304, 1));
        vecs.push_back(mk(0, 1, 32'h0,   32'h13572468, 4'hF, 0, 32'h0,        0));
        vecs.push_back(mk(0, 1, 32'h200, 32'h99999999, 4'hF, 1, 32'h0,        0));
        vecs.push_back(mk(0, 1, 32'h2,   32'h99999999, 4'hF, 1, 32'h0,        0));
        vecs.push_back(mk(1, 0, 32'h0,   32'h0,        4'hF, 0, 32'h13572468, 1));
        vecs.push_back(mk(0, 1, 32'h20,  32'h11111111, 4'hF, 0, 32'h0,        0));
        for (int i = 0; i < vecs.size(); i++) begin
            run_txn(vecs[i], 0);
        end

        // ---------------- reset during WAIT of a write ----------------
        if2.mem_wr = 1'b1; if2.mem_rd = 1'b0; if2.mem_addr = 32'h20;
        if2.mem_wr_data = 32'h22222222; if2.mem_be = 4'hF;
        @(negedge clk);
        chk("mrst_stall_accept", 32'(if2.mem_stall), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        if2.mem_wr = 1'b0;
        @(negedge clk);
        chk("mrst_stall_in_rst", 32'(if2.mem_stall), 32'd0);
        chk("mrst_done_in_rst", 32'(if2.mem_done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mrst_no_done", 32'(if2.mem_done), 32'd0);
            @(posedge clk); #1;
        end
        run_txn(mk(1, 0, 32'h20, 32'h0, 4'hF, 0, 32'h11111111, 1), 0);

        // ---------------- LATENCY=1 back-to-back requests ----------------
        l1v.push_back(mk(0, 1, 32'h0, 32'h0BADF00D, 4'hF, 0, 32'h0,        0));
        l1v.push_back(mk(0, 1, 32'h4, 32'h600DCAFE, 4'hF, 0, 32'h0,        0));
        l1v.push_back(mk(1, 0, 32'h0, 32'h0,        4'hF, 0, 32'h0BADF00D, 1));
        l1v.push_back(mk(1, 0, 32'h4, 32'h0,        4'hF, 0, 32'h600DCAFE, 1));
        l1v.push_back(mk(1, 0, 32'h6, 32'h0,        4'hF, 1, 32'h0,        1));
        l1v.push_back(mk(1, 0, 32'h4, 32'h0,        4'hF, 0, 32'h600DCAFE, 1));
        k = 0; cyc = 0; dones = 0;
        while (dones < l1v.size() && cyc < 40) begin
            if (cyc % 2 == 0 && k == dones && k < l1v.size()) begin
                exp_t e;
                if1.mem_rd = l1v[k].rd; if1.mem_wr = l1v[k].wr;
                if1.mem_addr = l1v[k].addr; if1.mem_wr_data = l1v[k].data;
                if1.mem_be = l1v[k].be;
                e.err = l1v[k].exp_err; e.data = l1v[k].exp_data;
                e.chk = l1v[k].chk_data; e.id = txn_id;
                txn_id++;
                sb1.push_back(e);
                k++;
            end
            @(negedge clk);
            chk($sformatf("l1_stall_c%0d", cyc), 32'(if1.mem_stall), 32'(cyc % 2 == 0));
            chk($sformatf("l1_done_c%0d", cyc), 32'(if1.mem_done), 32'(cyc % 2 == 1));
            got = (if1.mem_done === 1'b1);
            @(posedge clk); #1;
            if (got) begin
                dones++;
                if (dones == l1v.size()) begin
                    if1.mem_rd = 1'b0;
                    if1.mem_wr = 1'b0;
                end
            end
            cyc++;
        end
        chk("l1_all_done", dones, l1v.size());

        // ---------------- drain ----------------
        repeat (3) @(posedge clk);
        #1;
        chk("sb2_drained", sb2.size(), 32'd0);
        chk("sb1_drained", sb1.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
